// File: rtl/machine_csr_unit.sv
// ----------------------------------------------------------------------------
// machine_csr_unit
//   Machine-mode CSR file for the multi-cycle RV32I core. It shares the
//   32-bit data bus with the control sequencer. It serves CSR reads and
//   writes, captures trap state, and restores it on MRET. It also flags
//   illegal CSR accesses combinationally.
//
// Ports
//   clk        : clock, all state changes on posedge
//   rst        : synchronous active-low reset
//   addr       : CSR address (12 bits)
//   bus        : shared data bus. The unit drives it with the selected CSR
//                while read=1 and invalid=0, and leaves it high-Z otherwise.
//                The unit samples it as the write operand or the trap PC.
//   read       : drive the addressed CSR onto bus (combinational)
//   write      : update the addressed CSR at the next posedge
//   write_type : 01 write, 10 set bits, 11 clear bits, 00 no update
//   trap       : trap entry this cycle; bus carries the faulting PC
//   trap_cause : exception code recorded into mcause
//   ret        : MRET this cycle
//   invalid    : combinational illegal-access flag
// ----------------------------------------------------------------------------
module machine_csr_unit #(
  parameter logic [31:0] HART_ID    = 32'd0,
  parameter logic [31:0] MISA_VALUE = 32'h40000100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] addr,
  inout  wire  [31:0] bus,
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  write_type,
  input  logic        trap,
  input  logic [4:0]  trap_cause,
  input  logic        ret,
  output logic        invalid
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam logic [11:0] A_MIMPID    = 12'hF13;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    WT_NONE  = 2'b00,
    WT_WRITE = 2'b01,
    WT_SET   = 2'b10,
    WT_CLEAR = 2'b11
  } write_type_e;

  logic        r_mie_bit;
  logic        r_mpie_bit;
  logic [31:0] r_mie;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [31:0] r_mcycle;
  logic [31:0] r_mcycleh;

  logic        w_known;
  logic [31:0] w_rdata;
  logic [31:0] w_wdata;
  logic        w_do_write;
  logic [63:0] w_cycle_inc;
  logic [31:0] w_mstatus;

  // MPP is hardwired to machine mode; only MIE and MPIE are stored.
  assign w_mstatus   = {19'b0, 2'b11, 3'b0, r_mpie_bit, 3'b0, r_mie_bit, 3'b0};
  assign w_cycle_inc = {r_mcycleh, r_mcycle} + 64'd1;

  // Address decode and read mux.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is
    // inferred for addresses that the case does not list.
    w_known = 1'b1;
    w_rdata = 32'h0;
    case (addr)
      A_MSTATUS:              w_rdata = w_mstatus;
      A_MISA:                 w_rdata = MISA_VALUE;
      A_MIE:                  w_rdata = r_mie;
      A_MTVEC:                w_rdata = 32'h4;
      A_MSCRATCH:             w_rdata = r_mscratch;
      A_MEPC:                 w_rdata = r_mepc;
      A_MCAUSE:               w_rdata = r_mcause;
      A_MTVAL:                w_rdata = r_mtval;
      A_MIP:                  w_rdata = 32'h0;
      A_MCYCLE,  A_CYCLE:     w_rdata = r_mcycle;
      A_MCYCLEH, A_CYCLEH:    w_rdata = r_mcycleh;
      A_MVENDORID, A_MARCHID,
      A_MIMPID:               w_rdata = 32'h0;
      A_MHARTID:              w_rdata = HART_ID;
      default:                w_known = 1'b0;
    endcase
  end

  // addr[11:10]==2'b11 marks the read-only CSR space. The flag does not use
  // trap, so there is no combinational loop through the sequencer.
  assign invalid = ((read | write) & ~w_known) |
                   (write & (addr[11:10] == 2'b11));

  assign bus = (read && !invalid) ? w_rdata : 32'hz;

  // The read mux doubles as the old value for the set and clear forms.
  always_comb begin
    w_wdata = w_rdata;
    case (write_type_e'(write_type))
      WT_WRITE: w_wdata = bus;
      WT_SET:   w_wdata = w_rdata | bus;
      WT_CLEAR: w_wdata = w_rdata & ~bus;
      default:  w_wdata = w_rdata;
    endcase
  end

  assign w_do_write = write & ~invalid & ~trap & (write_type != WT_NONE);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // here sees the values from before the edge.
    if (!rst) begin
      r_mie_bit  <= 1'b0;
      r_mpie_bit <= 1'b0;
      r_mie      <= 32'h0;
      r_mscratch <= 32'h0;
      r_mepc     <= 32'h0;
      r_mcause   <= 32'h0;
      r_mtval    <= 32'h0;
      r_mcycle   <= 32'h0;
      r_mcycleh  <= 32'h0;
    end else begin
      // A software write replaces the increment for the half it targets.
      r_mcycle  <= (w_do_write && addr == A_MCYCLE)  ? w_wdata : w_cycle_inc[31:0];
      r_mcycleh <= (w_do_write && addr == A_MCYCLEH) ? w_wdata : w_cycle_inc[63:32];

      if (trap) begin
        r_mepc     <= bus & ~32'h3;
        r_mcause   <= {27'b0, trap_cause};
        r_mpie_bit <= r_mie_bit;
        r_mie_bit  <= 1'b0;
      end else begin
        if (ret) begin
          r_mie_bit  <= r_mpie_bit;
          r_mpie_bit <= 1'b1;
        end
        if (w_do_write) begin
          case (addr)
            A_MSTATUS: begin
              r_mie_bit  <= w_wdata[3];
              r_mpie_bit <= w_wdata[7];
            end
            A_MIE:      r_mie      <= w_wdata;
            A_MSCRATCH: r_mscratch <= w_wdata;
            A_MEPC:     r_mepc     <= w_wdata & ~32'h3;
            A_MCAUSE:   r_mcause   <= w_wdata;
            A_MTVAL:    r_mtval    <= w_wdata;
            default:    ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_machine_csr_unit.sv
module tb_machine_csr_unit;

  localparam logic [31:0] TB_HART_ID = 32'h0000_0003;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] addr = 12'h0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  write_type = 2'b00;
  logic        trap = 1'b0;
  logic [4:0]  trap_cause = 5'd0;
  logic        ret = 1'b0;
  logic        invalid;
  logic        tb_drv = 1'b0;
  logic [31:0] tb_bus = 32'h0;
  wire  [31:0] bus;

  assign bus = tb_drv ? tb_bus : 32'hz;

  machine_csr_unit #(.HART_ID(TB_HART_ID), .MISA_VALUE(32'h40000100)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .bus        (bus),
    .read       (read),
    .write      (write),
    .write_type (write_type),
    .trap       (trap),
    .trap_cause (trap_cause),
    .ret        (ret),
    .invalid    (invalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    bit          chk_bus;
    logic [31:0] exp_bus;
    logic        exp_inv;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Records what the DUT must show in the current cycle.
  task automatic push(input string name, input bit chk_bus,
                      input logic [31:0] exp_bus, input logic exp_inv);
    exp_t e;
    e.cyc = cyc; e.name = name; e.chk_bus = chk_bus;
    e.exp_bus = exp_bus; e.exp_inv = exp_inv;
    exp_q.push_back(e);
  endtask

  // The monitor compares expectations for the current cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_total++;
        if (e.cyc != cyc)
          $display("FAIL %s: missed sample (cycle %0d, now %0d)", e.name, e.cyc, cyc);
        else if (e.chk_bus && bus !== e.exp_bus)
          $display("FAIL %s: bus got %08h expected %08h", e.name, bus, e.exp_bus);
        else if (invalid !== e.exp_inv)
          $display("FAIL %s: invalid got %b expected %b", e.name, invalid, e.exp_inv);
        else
          n_pass++;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0; write_type = 2'b00; trap = 1'b0;
    ret = 1'b0; tb_drv = 1'b0; tb_bus = 32'h0; trap_cause = 5'd0;
  endtask

  task automatic do_read(input logic [11:0] a, input logic [31:0] exp, input string name);
    next_cycle();
    addr = a; read = 1'b1;
    push(name, 1'b1, exp, 1'b0);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [1:0] wt,
                          input logic [31:0] data, input logic exp_inv, input string name);
    next_cycle();
    addr = a; write = 1'b1; write_type = wt; tb_drv = 1'b1; tb_bus = data;
    push(name, 1'b0, 32'h0, exp_inv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rst = 1'b0;
    next_cycle(); next_cycle();
    rst = 1'b1;

    do_read(12'h300, 32'h00001800, "rst_mstatus");
    do_read(12'h341, 32'h00000000, "rst_mepc");
    do_read(12'hF14, TB_HART_ID,   "mhartid");
    do_read(12'h301, 32'h40000100, "misa");
    do_read(12'h305, 32'h00000004, "mtvec");
    do_read(12'h344, 32'h00000000, "mip");

    // mscratch: write, set and clear
    do_write(12'h340, 2'b01, 32'hDEADBEEF, 1'b0, "wr_mscratch");
    do_read (12'h340, 32'hDEADBEEF, "mscratch_w");
    do_write(12'h340, 2'b10, 32'h0000000F, 1'b0, "set_mscratch");
    do_read (12'h340, 32'hDEADBEEF, "mscratch_s");
    do_write(12'h340, 2'b11, 32'hF0000000, 1'b0, "clr_mscratch");
    do_read (12'h340, 32'h0EADBEEF, "mscratch_c");

    // Field masks and ignored writes
    do_write(12'h341, 2'b01, 32'h00000013, 1'b0, "wr_mepc");
    do_read (12'h341, 32'h00000010, "mepc_mask");
    do_write(12'h301, 2'b01, 32'h00000000, 1'b0, "wr_misa");
    do_read (12'h301, 32'h40000100, "misa_ignored");
    do_write(12'h343, 2'b01, 32'h00000055, 1'b0, "wr_mtval");
    do_read (12'h343, 32'h00000055, "mtval");

    // Trap entry and MRET
    do_write(12'h300, 2'b10, 32'h00000008, 1'b0, "set_mie");
    do_read (12'h300, 32'h00001808, "mstatus_mie");
    next_cycle();
    addr = 12'h000; trap = 1'b1; trap_cause = 5'd2; tb_drv = 1'b1; tb_bus = 32'h00000123;
    do_read (12'h341, 32'h00000120, "trap_mepc");
    do_read (12'h342, 32'h00000002, "trap_mcause");
    do_read (12'h300, 32'h00001880, "trap_mstatus");
    next_cycle();
    addr = 12'h341; read = 1'b1; ret = 1'b1;
    push("ret_mepc_read", 1'b1, 32'h00000120, 1'b0);
    do_read (12'h300, 32'h00001888, "ret_mstatus");

    // Illegal accesses
    next_cycle();
    addr = 12'h7C0; read = 1'b1; tb_drv = 1'b1; tb_bus = 32'h0;
    push("rd_unknown", 1'b1, 32'h0, 1'b1);
    do_write(12'hF11, 2'b01, 32'h0000AAAA, 1'b1, "wr_readonly");
    do_read (12'hF11, 32'h00000000, "mvendorid");
    next_cycle();
    addr = 12'hC00; read = 1'b1;
    push("rd_cycle_legal", 1'b0, 32'h0, 1'b0);

    // Cycle counter
    do_write(12'hB00, 2'b01, 32'h00000010, 1'b0, "wr_mcycle");
    do_read (12'hB00, 32'h00000010, "mcycle_0");
    do_read (12'hB00, 32'h00000011, "mcycle_1");
    do_write(12'hB80, 2'b01, 32'h00000005, 1'b0, "wr_mcycleh");
    do_write(12'hB00, 2'b01, 32'hFFFFFFFF, 1'b0, "wr_mcycle_max");
    do_read (12'hB00, 32'hFFFFFFFF, "mcycle_max");
    do_read (12'hB80, 32'h00000006, "mcycleh_carry");
    do_read (12'hC00, 32'h00000001, "cycle_mirror");
    do_read (12'hC80, 32'h00000006, "cycleh_mirror");

    // Trap beats a simultaneous write
    next_cycle();
    addr = 12'h342; write = 1'b1; write_type = 2'b01; trap = 1'b1; trap_cause = 5'd5;
    tb_drv = 1'b1; tb_bus = 32'h00000207;
    push("trap_and_write", 1'b0, 32'h0, 1'b0);
    do_read (12'h342, 32'h00000005, "trap_wins_mcause");
    do_read (12'h341, 32'h00000204, "trap_wins_mepc");
    do_read (12'h300, 32'h00001880, "trap_wins_mstatus");

    // No access means no flag and no drive
    next_cycle();
    addr = 12'h340; tb_drv = 1'b1; tb_bus = 32'h0;
    push("idle_known", 1'b1, 32'h0, 1'b0);
    next_cycle();
    addr = 12'h7C0;
    push("idle_unknown", 1'b0, 32'h0, 1'b0);

    // Reset discards a pending write
    next_cycle();
    rst = 1'b0; addr = 12'h340; write = 1'b1; write_type = 2'b01;
    tb_drv = 1'b1; tb_bus = 32'h12345678;
    next_cycle();
    rst = 1'b1;
    do_read (12'h340, 32'h00000000, "rst_drops_write");
    do_read (12'h300, 32'h00001800, "rst_mstatus_again");

    next_cycle(); next_cycle(); next_cycle();
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_total++;
      $display("FAIL %s: never sampled", e.name);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
